// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: opcodes, funct3 codes, access-size decode and FSM states for the memory stage
package rv32_mem_pkg;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic {ST_IDLE, ST_SPLIT} state_t;
   typedef struct packed {
      logic       ok;
      logic [2:0] size;
      logic       sgn;
   } dec_t;
   // unsigned load funct3 codes are reserved for stores
   function automatic dec_t size_dec(input logic [2:0] f3, input logic is_store);
      dec_t d;
      case (f3)
         F3_B:    d = '{1'b1, 3'd1, !is_store};
         F3_H:    d = '{1'b1, 3'd2, !is_store};
         F3_W:    d = '{1'b1, 3'd4, 1'b0};
         F3_BU:   d = '{!is_store, 3'd1, 1'b0};
         F3_HU:   d = '{!is_store, 3'd2, 1'b0};
         default: d = '{1'b0, 3'd1, 1'b0};
      endcase
      return d;
   endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: 32-bit word RAM with four byte-lane write enables and two combinational read ports
module dmem_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic [3:0]        i_be,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [31:0]       i_wdata,
   input  logic [ADDR_W-1:0] i_raddr0,
   input  logic [ADDR_W-1:0] i_raddr1,
   output logic [31:0]       o_rdata0,
   output logic [31:0]       o_rdata1
);
   logic [31:0] r_mem [0:(1<<ADDR_W)-1];
   // write only the enabled byte lanes
   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
   assign o_rdata0 = r_mem[i_raddr0];
   assign o_rdata1 = r_mem[i_raddr1];
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: memory-stage load/store responder with optional two-cycle word-crossing split
module data_mem_resp import rv32_mem_pkg::*; #(
   parameter int ADDR_W         = 10,
   parameter bit ALLOW_MISALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic        i_mem_rw,
   output logic [31:0] o_load_data,
   output logic        o_load_valid,
   output logic        o_stall,
   output logic        o_misalign_fault,
   output logic        o_illegal_fault
);
   state_t            r_state, w_next;
   dec_t              w_dec;
   logic              w_is_st, w_is_ld, w_acc, w_ill, w_cross;
   logic              w_ld_done, w_mis, w_ill_p, w_unused;
   logic [1:0]        w_off;
   logic [ADDR_W-1:0] w_idx, w_idx1, w_waddr;
   logic [7:0]        w_mask;
   logic [3:0]        w_be;
   logic [31:0]       w_wrot, w_rd0, w_rd1, w_lo, w_raw, w_ext;
   logic [31:0]       r_hold, r_load_data;
   logic              r_load_valid, r_mis, r_ill;

   assign w_is_st  = i_instr[6:0] == OP_STORE && i_mem_rw;
   assign w_is_ld  = i_instr[6:0] == OP_LOAD;
   assign w_dec    = size_dec(i_instr[14:12], w_is_st);
   assign w_acc    = (w_is_st || w_is_ld) && w_dec.ok;
   assign w_ill    = (w_is_st || w_is_ld) && !w_dec.ok;
   assign w_off    = i_addr[1:0];
   assign w_idx    = i_addr[ADDR_W+1:2];
   assign w_idx1   = w_idx + ADDR_W'(1);
   assign w_cross  = w_acc && ({1'b0, w_off} + w_dec.size > 3'd4);
   assign w_mask   = ((8'd1 << w_dec.size) - 8'd1) << w_off;
   assign w_wrot   = 32'({i_wdata, i_wdata} >> (6'd32 - {1'b0, w_off, 3'b000}));
   assign w_lo     = r_state == ST_SPLIT ? r_hold : w_rd0;
   assign w_raw    = 32'({w_rd1, w_lo} >> {w_off, 3'b000});
   assign w_ext    = w_dec.size == 3'd1 ? {{24{w_dec.sgn & w_raw[7]}}, w_raw[7:0]} :
                     w_dec.size == 3'd2 ? {{16{w_dec.sgn & w_raw[15]}}, w_raw[15:0]} : w_raw;
   assign w_unused = &{1'b0, i_instr[31:15], i_instr[11:7], i_addr[31:ADDR_W+2]};

   dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk      (clk),
      .i_be     (w_be),
      .i_waddr  (w_waddr),
      .i_wdata  (w_wrot),
      .i_raddr0 (w_idx),
      .i_raddr1 (w_idx1),
      .o_rdata0 (w_rd0),
      .o_rdata1 (w_rd1)
   );

   // state register; reset abandons any pending second half
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;

   // a crossing request in IDLE spends exactly one extra cycle in SPLIT
   always_comb
      w_next = (r_state == ST_IDLE && o_stall) ? ST_SPLIT : ST_IDLE;

   // RAM controls and event strobes; SPLIT finishes the held request's high word
   always_comb begin
      o_stall   = r_state == ST_IDLE && w_cross && ALLOW_MISALIGN;
      w_waddr   = r_state == ST_SPLIT ? w_idx1 : w_idx;
      w_be      = (!w_is_st || !w_acc) ? 4'b0000 :
                  r_state == ST_SPLIT ? w_mask[7:4] :
                  (w_cross && !ALLOW_MISALIGN) ? 4'b0000 : w_mask[3:0];
      w_ld_done = w_is_ld && w_acc && (r_state == ST_SPLIT || !w_cross);
      w_mis     = r_state == ST_IDLE && w_cross && !ALLOW_MISALIGN;
      w_ill_p   = r_state == ST_IDLE && w_ill;
   end

   // registered load result, pulse outputs and low-word hold for split loads
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_load_data  <= '0;
         r_load_valid <= 1'b0;
         r_mis        <= 1'b0;
         r_ill        <= 1'b0;
         r_hold       <= '0;
      end else begin
         r_load_valid <= w_ld_done;
         r_mis        <= w_mis;
         r_ill        <= w_ill_p;
         if (w_ld_done) r_load_data <= w_ext;
         if (o_stall && w_is_ld) r_hold <= w_rd0;
      end

   assign o_load_data      = r_load_data;
   assign o_load_valid     = r_load_valid;
   assign o_misalign_fault = r_mis;
   assign o_illegal_fault  = r_ill;
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: scoreboard bench for split (A) and faulting (B) configurations
module tb_data_mem_resp;
   localparam logic [31:0] I_SB  = 32'h0000_0023;
   localparam logic [31:0] I_SW  = 32'h0000_2023;
   localparam logic [31:0] I_S3  = 32'h0000_3023;
   localparam logic [31:0] I_LB  = 32'h0000_0003;
   localparam logic [31:0] I_LH  = 32'h0000_1003;
   localparam logic [31:0] I_LW  = 32'h0000_2003;
   localparam logic [31:0] I_L3  = 32'h0000_3003;
   localparam logic [31:0] I_LBU = 32'h0000_4003;
   localparam logic [31:0] I_LHU = 32'h0000_5003;
   localparam int EV_LOAD = 0, EV_MIS = 1, EV_ILL = 2, NONE = -1;

   typedef struct {
      int          kind;
      logic [31:0] data;
      int          cyc;
   } ev_t;

   logic        clk = 1'b0, rst = 1'b1, sel_b = 1'b0, mem_rw = 1'b0;
   logic [31:0] instr = '0, addr = '0, wdata = '0;
   logic [31:0] a_instr, b_instr, a_ld, b_ld;
   logic        a_rw, b_rw, a_lv, b_lv, a_stall, b_stall, a_mf, b_mf, a_if, b_if;
   int          cyc = 0, checks = 0, errors = 0;
   ev_t         qa[$], qb[$];

   assign a_instr = sel_b ? 32'h0 : instr;
   assign b_instr = sel_b ? instr : 32'h0;
   assign a_rw    = !sel_b && mem_rw;
   assign b_rw    = sel_b && mem_rw;

   data_mem_resp #(.ADDR_W(10), .ALLOW_MISALIGN(1'b1)) dut_a (
      .clk(clk), .rst(rst), .i_instr(a_instr), .i_addr(addr), .i_wdata(wdata), .i_mem_rw(a_rw),
      .o_load_data(a_ld), .o_load_valid(a_lv), .o_stall(a_stall),
      .o_misalign_fault(a_mf), .o_illegal_fault(a_if));

   data_mem_resp #(.ADDR_W(10), .ALLOW_MISALIGN(1'b0)) dut_b (
      .clk(clk), .rst(rst), .i_instr(b_instr), .i_addr(addr), .i_wdata(wdata), .i_mem_rw(b_rw),
      .o_load_data(b_ld), .o_load_valid(b_lv), .o_stall(b_stall),
      .o_misalign_fault(b_mf), .o_illegal_fault(b_if));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %h required %h (cycle %0d)", name, got, req, cyc);
      end
   endtask

   task automatic check_ev(input int inst, input int kind, input logic [31:0] d);
      ev_t e;
      checks++;
      if ((inst == 1 ? qb.size() : qa.size()) == 0) begin
         errors++;
         $display("FAIL unexpected_event inst=%0d kind=%0d data=%h cycle=%0d required none", inst, kind, d, cyc);
      end else begin
         if (inst == 1) e = qb.pop_front();
         else e = qa.pop_front();
         if (e.kind != kind || e.cyc != cyc || (kind == EV_LOAD && e.data !== d)) begin
            errors++;
            $display("FAIL event inst=%0d got kind=%0d data=%h cycle=%0d required kind=%0d data=%h cycle=%0d",
                     inst, kind, d, cyc, e.kind, e.data, e.cyc);
         end
      end
   endtask

   // monitor: every pulse the DUTs present is matched against the scoreboard
   always @(negedge clk)
      if (!rst) begin
         if (a_lv) check_ev(0, EV_LOAD, a_ld);
         if (a_mf) check_ev(0, EV_MIS, 32'h0);
         if (a_if) check_ev(0, EV_ILL, 32'h0);
         if (b_lv) check_ev(1, EV_LOAD, b_ld);
         if (b_mf) check_ev(1, EV_MIS, 32'h0);
         if (b_if) check_ev(1, EV_ILL, 32'h0);
      end

   task automatic op(input logic b, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] wd,
                     input logic rw, input logic st, input int kind, input logic [31:0] ed);
      ev_t e;
      @(posedge clk); #1;
      sel_b = b; instr = ins; addr = a; wdata = wd; mem_rw = rw;
      if (kind != NONE) begin
         e.kind = kind; e.data = ed; e.cyc = cyc + (st ? 2 : 1);
         if (b) qb.push_back(e);
         else qa.push_back(e);
      end
      @(negedge clk);
      check("stall", {31'b0, b ? b_stall : a_stall}, {31'b0, st});
      if (st) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("stall_split", {31'b0, a_stall}, 32'h0);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      instr = '0; mem_rw = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_load_data", a_ld, 32'h0);
      check("rst_load_valid", {31'b0, a_lv}, 32'h0);
      check("rst_stall", {31'b0, a_stall}, 32'h0);
      check("rst_faults", {30'b0, b_mf, b_if}, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      // aligned word store then immediate load, halfword sign/zero extension
      op(0, I_SW,  32'h100, 32'hDEADBEEF, 1, 0, NONE, 0);
      op(0, I_LW,  32'h100, 0, 0, 0, EV_LOAD, 32'hDEADBEEF);
      op(0, I_LH,  32'h100, 0, 0, 0, EV_LOAD, 32'hFFFFBEEF);
      op(0, I_LHU, 32'h102, 0, 0, 0, EV_LOAD, 32'h0000DEAD);
      // byte store into a cleared word
      op(0, I_SW,  32'h100, 32'h0, 1, 0, NONE, 0);
      op(0, I_SB,  32'h101, 32'h80, 1, 0, NONE, 0);
      op(0, I_LB,  32'h101, 0, 0, 0, EV_LOAD, 32'hFFFFFF80);
      op(0, I_LBU, 32'h101, 0, 0, 0, EV_LOAD, 32'h00000080);
      op(0, I_LW,  32'h100, 0, 0, 0, EV_LOAD, 32'h00008000);
      // word-crossing store and load split over two cycles
      op(0, I_SW,  32'h100, 32'h0, 1, 0, NONE, 0);
      op(0, I_SW,  32'h104, 32'h0, 1, 0, NONE, 0);
      op(0, I_SW,  32'h102, 32'h11223344, 1, 1, NONE, 0);
      op(0, I_LW,  32'h100, 0, 0, 0, EV_LOAD, 32'h33440000);
      op(0, I_LW,  32'h104, 0, 0, 0, EV_LOAD, 32'h00001122);
      op(0, I_LW,  32'h102, 0, 0, 1, EV_LOAD, 32'h11223344);
      op(0, I_LH,  32'h102, 0, 0, 0, EV_LOAD, 32'h00003344);
      // last word wraps to word 0
      op(0, I_SB,  32'hFFF, 32'hAB, 1, 0, NONE, 0);
      op(0, I_SB,  32'h000, 32'h7F, 1, 0, NONE, 0);
      op(0, I_LH,  32'hFFF, 0, 0, 1, EV_LOAD, 32'h00007FAB);
      // reset in the second cycle of a split store
      op(0, I_SW,  32'h104, 32'h0, 1, 0, NONE, 0);
      op(0, I_SW,  32'h108, 32'h55667788, 1, 0, NONE, 0);
      @(posedge clk); #1;
      instr = I_SW; addr = 32'h106; wdata = 32'hAABBCCDD; mem_rw = 1'b1;
      @(negedge clk);
      check("stall_mid", {31'b0, a_stall}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b1; instr = '0; mem_rw = 1'b0;
      @(negedge clk);
      check("rst_split_stall", {31'b0, a_stall}, 32'h0);
      check("rst_split_valid", {31'b0, a_lv}, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      op(0, I_LW,  32'h104, 0, 0, 0, EV_LOAD, 32'hCCDD0000);
      op(0, I_LW,  32'h108, 0, 0, 0, EV_LOAD, 32'h55667788);
      // faulting configuration: misaligned and reserved funct3 leave RAM untouched
      op(1, I_SW,  32'h100, 32'hCAFEF00D, 1, 0, NONE, 0);
      op(1, I_SW,  32'h104, 32'h01234567, 1, 0, NONE, 0);
      op(1, I_LW,  32'h103, 0, 0, 0, EV_MIS, 0);
      op(1, I_SW,  32'h102, 32'hFFFFFFFF, 1, 0, EV_MIS, 0);
      op(1, I_LH,  32'h103, 0, 0, 0, EV_MIS, 0);
      op(1, I_L3,  32'h100, 0, 0, 0, EV_ILL, 0);
      op(1, I_S3,  32'h100, 32'h12345678, 1, 0, EV_ILL, 0);
      op(1, I_LW,  32'h100, 0, 0, 0, EV_LOAD, 32'hCAFEF00D);
      op(1, I_LW,  32'h104, 0, 0, 0, EV_LOAD, 32'h01234567);
      op(1, I_LHU, 32'h102, 0, 0, 0, EV_LOAD, 32'h0000CAFE);
      idle();
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("pending_a", qa.size(), 32'h0);
      check("pending_b", qb.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
Memory-stage responder. It consumes the access-stage bundle (instruction, ALU address, store data, MemRW) and performs the data-memory transaction against a local byte-lane RAM. It executes SB/SH/SW with byte enables and returns sign- or zero-extended LB/LH/LW/LBU/LHU data to writeback. Word-crossing (misaligned) accesses are either split into two word accesses, with a pipeline stall, or faulted, as set by a parameter.

Parameters:
ADDR_W, 10, word-address bits; RAM depth is 2^ADDR_W 32-bit words.
ALLOW_MISALIGN, 1, 1 = split word-crossing accesses into two cycles; 0 = fault and skip the access.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr  in  32  instruction in access stage; opcode [6:0], funct3 [14:12]
addr  in  32  effective address (ALU result)
wdata  in  32  store data (rs2 value)
mem_rw  in  1  1 = store enabled by access stage
load_data  out  32  extended load result, registered
load_valid  out  1  one-cycle pulse when load_data is updated
stall  out  1  combinational; upstream holds all inputs for one cycle
misalign_fault  out  1  one-cycle pulse on a faulted misaligned access
illegal_fault  out  1  one-cycle pulse on a reserved funct3

Behaviour:
- Classification:
  - Store = opcode 0100011 and mem_rw=1.
  - Load = opcode 0000011.
  - Anything else = no access.
- Size decode:
  - Stores: funct3 000/001/010 map to size 1/2/4 bytes. Any other store funct3 gives no write and pulses illegal_fault at N+1.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Others give no read and pulse illegal_fault at N+1.
- Addressing:
  - off = addr[1:0]; idx = addr[ADDR_W+1:2]; upper address bits are ignored.
  - Crossing when off+size > 4.
  - Second word index is idx+1 mod 2^ADDR_W, so the last word wraps to word 0.
- RAM: 4 byte lanes, combinational read, synchronous write with per-lane enable.
- Aligned store, request in cycle N:
  - Lanes [off .. off+size-1] written at the end of N, with wdata bytes rotated left by off.
  - stall=0.
- Aligned load, request in cycle N:
  - Selected bytes extracted at bit offset 8*off and extended (LB/LH sign from bit 7/15; LBU/LHU zero).
  - Result registered at the end of N, so load_data is valid in N+1 with load_valid=1.
  - Latency is 1 and stall=0.
- FSM states IDLE and SPLIT (ALLOW_MISALIGN=1):
  - IDLE with a crossing request: stall=1 in N. The low part goes to word idx (lanes off..3); for loads, those bytes go to a hold register. Go to SPLIT.
  - SPLIT (cycle N+1): stall=0. The held request is not re-decoded as new. The high part goes to word idx+1 (lanes 0..off+size-5). A load assembles hold plus high bytes, extends, and registers, giving load_valid in N+2. Go to IDLE.
  - A new request in N+2 is accepted normally.
- ALLOW_MISALIGN=0, crossing request: no RAM write or read, misalign_fault=1 in N+1, load_valid=0, stall=0.
- Store then load of the same bytes in consecutive cycles: the load sees the new data, because the write lands before the combinational read.
- Reset:
  - load_data=0, load_valid=0, misalign_fault=0, illegal_fault=0, FSM=IDLE, hold register=0.
  - stall=0 because it is a function of the IDLE state.
  - RAM contents are not reset.
- Reset during SPLIT: the second half is abandoned. A first-half store write persists; no load_valid is produced.
- Outputs that pulse are deasserted in every cycle without a corresponding event.

Decomposition:
- Package rv32_mem_pkg:
  - OP_LOAD=7'b0000011 and OP_STORE=7'b0100011.
  - funct3 constants F3_B/H/W/BU/HU.
  - Size/extension decode function returning {size, signed}.
  - State encoding ST_IDLE/ST_SPLIT.
- Sub-module dmem_ram: 2^ADDR_W x 32, 4 byte enables, one write port, two combinational read ports (idx and idx+1).
- Lane rotation, extension, and the FSM stay in data_mem_resp.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, then LW 0x100 -> load_data=0xDEADBEEF at N+1, load_valid single pulse, stall=0 throughout.
- SB 0x101 wdata=0x80 over word 0x00000000, then LB 0x101 -> 0xFFFFFF80; LBU 0x101 -> 0x00000080; word 0x100 reads 0x00008000.
- Misaligned with ALLOW_MISALIGN=1:
  - SW 0x102 wdata=0x11223344 -> stall=1 in N only; word 0x100 upper half=0x3344, word 0x104 lower half=0x1122.
  - LW 0x102 -> 0x11223344 with load_valid at N+2.
- Wrap: LH at addr 4*(2^ADDR_W)-1 with byte 0xAB there and byte 0x7F at word 0 lane 0 -> load_data=0x00007FAB.
- Misaligned with ALLOW_MISALIGN=0: LW 0x103 -> misalign_fault pulse at N+1, no load_valid, RAM unchanged. Funct3=011 load -> illegal_fault pulse.
- Reset mid-split: SW 0x106 wdata=0xAABBCCDD, rst asserted in N+1 -> state IDLE, stall=0, word 0x104 upper half=0xCCDD, word 0x108 unchanged.
